enemy_controller: RTL and testbench

- Drives one stage enemy that chases the main character, winds up and strikes, and takes damage from the character's attack states.
- Generates the is_attacked pulse consumed by the main character; consumes the character's position and 4-bit animation state.
- One instance per enemy, enabled by stage logic, with sprite rendering driven from its position and state outputs.

---
 rtl/enemy_pkg.sv | 22 ++
 rtl/range_check.sv | 24 ++
 rtl/enemy_controller.sv | 186 ++++++++++++++++++
 tb/tb_enemy_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the stage enemy.
//   enemy_state_e : 3-bit FSM state codes, also exported to the sprite selector
//   PS_*          : main character animation state codes consumed by the enemy
package enemy_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StChase    = 3'd1,
        StWindup   = 3'd2,
        StStrike   = 3'd3,
        StCooldown = 3'd4,
        StHurt     = 3'd5,
        StDead     = 3'd6
    } enemy_state_e;

    localparam logic [3:0] PS_FRONT = 4'hA;  // attack towards -v
    localparam logic [3:0] PS_BACK  = 4'hB;  // attack towards +v
    localparam logic [3:0] PS_LEFT  = 4'hC;  // attack towards +h
    localparam logic [3:0] PS_RIGHT = 4'hD;  // attack towards -h
    localparam logic [3:0] PS_EMPTY = 4'hF;

endpackage

// File: rtl/range_check.sv
// Combinational box test between two 10-bit points.
//   a_h, a_v : first point
//   b_h, b_v : second point
//   in_range : |a_h-b_h| <= RANGE and |a_v-b_v| <= RANGE
module range_check #(
    parameter int unsigned RANGE = 12
) (
    input  logic [9:0] a_h,
    input  logic [9:0] a_v,
    input  logic [9:0] b_h,
    input  logic [9:0] b_v,
    output logic       in_range
);

    logic [9:0] dh;
    logic [9:0] dv;

    always_comb begin
        dh       = (a_h >= b_h) ? (a_h - b_h) : (b_h - a_h);
        dv       = (a_v >= b_v) ? (a_v - b_v) : (b_v - a_v);
        in_range = (dh <= 10'(RANGE)) && (dv <= 10'(RANGE));
    end

endmodule

// File: rtl/enemy_controller.sv
// Stage enemy: chases the character, winds up and strikes, takes damage from the
// character's directional attacks, dies and respawns.
//   clk, rst             : clock, asynchronous active-low reset
//   enable               : enemy belongs to the current stage
//   respawn              : one-cycle pulse reloading spawn position and hp
//   gameover             : freezes the enemy in IDLE
//   player_h/v/state     : character position and animation state
//   enemy_h/v            : enemy position
//   enemy_state          : FSM state code for the sprite selector
//   hp                   : remaining hit points
//   is_attacked          : one-cycle strike pulse to the character
//   defeated             : high while in DEAD
module enemy_controller
    import enemy_pkg::*;
#(
    parameter int unsigned SPAWN_H      = 250,
    parameter int unsigned SPAWN_V      = 110,
    parameter int unsigned MAX_HP       = 3,
    parameter int unsigned MOVE_DIV     = 4,
    parameter int unsigned ATK_RANGE    = 12,
    parameter int unsigned HIT_RANGE    = 20,
    parameter int unsigned WINDUP_CYC   = 30,
    parameter int unsigned COOLDOWN_CYC = 60,
    parameter int unsigned INVULN_CYC   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       respawn,
    input  logic       gameover,
    input  logic [9:0] player_h,
    input  logic [9:0] player_v,
    input  logic [3:0] player_state,
    output logic [9:0] enemy_h,
    output logic [9:0] enemy_v,
    output logic [2:0] enemy_state,
    output logic [3:0] hp,
    output logic       is_attacked,
    output logic       defeated
);

    localparam int unsigned StepW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    enemy_state_e     state;
    logic [7:0]       timer;
    logic [StepW-1:0] step;

    logic       in_atk;
    logic       in_hit;
    logic       player_hit;
    logic       hittable;
    logic [3:0] hp_dec;

    range_check #(
        .RANGE (ATK_RANGE)
    ) u_atk_range (
        .a_h      (player_h),
        .a_v      (player_v),
        .b_h      (enemy_h),
        .b_v      (enemy_v),
        .in_range (in_atk)
    );

    range_check #(
        .RANGE (HIT_RANGE)
    ) u_hit_range (
        .a_h      (player_h),
        .a_v      (player_v),
        .b_h      (enemy_h),
        .b_v      (enemy_v),
        .in_range (in_hit)
    );

    // A character attack only lands if the enemy is on the side it faces.
    always_comb begin
        player_hit = 1'b0;
        if (in_hit) begin
            case (player_state)
                PS_LEFT:  player_hit = (enemy_h >= player_h);
                PS_RIGHT: player_hit = (enemy_h <= player_h);
                PS_BACK:  player_hit = (enemy_v >= player_v);
                PS_FRONT: player_hit = (enemy_v <= player_v);
                PS_EMPTY: player_hit = 1'b0;
                default:  player_hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        hittable = (state == StChase) || (state == StWindup) ||
                   (state == StStrike) || (state == StCooldown);
        hp_dec   = (hp == 4'd0) ? 4'd0 : (hp - 4'd1);
    end

    assign enemy_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            enemy_h     <= 10'(SPAWN_H);
            enemy_v     <= 10'(SPAWN_V);
            hp          <= 4'(MAX_HP);
            is_attacked <= 1'b0;
            defeated    <= 1'b0;
            timer       <= 8'd0;
            step        <= '0;
        end else begin
            // The strike pulse is only ever set on entry to STRIKE.
            is_attacked <= 1'b0;
            if (gameover) begin
                state    <= StIdle;
                defeated <= 1'b0;
                timer    <= 8'd0;
                step     <= '0;
            end else if (respawn && enable) begin
                state    <= StChase;
                enemy_h  <= 10'(SPAWN_H);
                enemy_v  <= 10'(SPAWN_V);
                hp       <= 4'(MAX_HP);
                defeated <= 1'b0;
                timer    <= 8'd0;
                step     <= '0;
            end else if (!enable) begin
                state    <= StIdle;
                defeated <= 1'b0;
                timer    <= 8'd0;
                step     <= '0;
            end else if (hittable && player_hit) begin
                // Taking a hit pre-empts any strike about to be launched.
                hp    <= hp_dec;
                timer <= 8'(INVULN_CYC - 1);
                step  <= '0;
                if (hp_dec == 4'd0) begin
                    state    <= StDead;
                    defeated <= 1'b1;
                end else begin
                    state <= StHurt;
                end
            end else begin
                case (state)
                    StChase: begin
                        if (in_atk) begin
                            state <= StWindup;
                            timer <= 8'(WINDUP_CYC - 1);
                            step  <= '0;
                        end else if (step == StepW'(MOVE_DIV - 1)) begin
                            step <= '0;
                            // One-pixel steps toward the player cannot overshoot.
                            if (enemy_h != player_h) begin
                                enemy_h <= (player_h > enemy_h) ? (enemy_h + 10'd1)
                                                                : (enemy_h - 10'd1);
                            end else if (enemy_v != player_v) begin
                                enemy_v <= (player_v > enemy_v) ? (enemy_v + 10'd1)
                                                                : (enemy_v - 10'd1);
                            end
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                    StWindup: begin
                        if (timer == 8'd0) begin
                            state       <= StStrike;
                            is_attacked <= in_atk;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                    StStrike: begin
                        state <= StCooldown;
                        timer <= 8'(COOLDOWN_CYC - 1);
                    end
                    StCooldown, StHurt: begin
                        if (timer == 8'd0) begin
                            state <= StChase;
                            step  <= '0;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                    default: ;  // IDLE and DEAD wait for respawn
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_controller.sv
module tb_enemy_controller;
    import enemy_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       respawn;
    logic       gameover;
    logic [9:0] player_h;
    logic [9:0] player_v;
    logic [3:0] player_state;
    logic [9:0] enemy_h;
    logic [9:0] enemy_v;
    logic [2:0] enemy_state;
    logic [3:0] hp;
    logic       is_attacked;
    logic       defeated;

    int checks = 0;
    int errors = 0;
    logic prev_att = 1'b0;

    enemy_controller dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .respawn      (respawn),
        .gameover     (gameover),
        .player_h     (player_h),
        .player_v     (player_v),
        .player_state (player_state),
        .enemy_h      (enemy_h),
        .enemy_v      (enemy_v),
        .enemy_state  (enemy_state),
        .hp           (hp),
        .is_attacked  (is_attacked),
        .defeated     (defeated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ph;
        logic [9:0] pv;
        logic [3:0] ps;
        logic [2:0] exp_state;
        logic [3:0] exp_hp;
    } vec_t;

    vec_t vecs[13];

    // The strike pulse may only appear in STRIKE and never twice in a row.
    always @(negedge clk) begin
        if (rst && is_attacked) begin
            checks++;
            if (enemy_state != 3'd3 || prev_att) begin
                errors++;
                $display("FAIL pulse_rule: is_attacked=1 state=%0d prev=%0d want state 3 prev 0",
                         enemy_state, prev_att);
            end
        end
        prev_att = is_attacked;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic do_respawn();
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input string name, output int n);
        n = 0;
        while (enemy_state != tgt && n < 1000) begin
            tick();
            n++;
        end
        if (enemy_state != tgt) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout in state %0d want %0d", name, enemy_state, tgt);
        end
    endtask

    task automatic set_player(input logic [9:0] h, input logic [9:0] v, input logic [3:0] s);
        player_h     = h;
        player_v     = v;
        player_state = s;
    endtask

    initial begin
        int n;
        vecs[0]  = '{10'd150, 10'd110, PS_EMPTY, 3'd1, 4'd3};  // far away
        vecs[1]  = '{10'd240, 10'd110, PS_LEFT,  3'd5, 4'd2};  // left attack lands
        vecs[2]  = '{10'd240, 10'd110, PS_RIGHT, 3'd2, 4'd3};  // wrong side, in strike reach
        vecs[3]  = '{10'd260, 10'd110, PS_RIGHT, 3'd5, 4'd2};
        vecs[4]  = '{10'd250, 10'd125, PS_BACK,  3'd1, 4'd3};  // wrong side, out of reach
        vecs[5]  = '{10'd250, 10'd125, PS_FRONT, 3'd5, 4'd2};
        vecs[6]  = '{10'd230, 10'd110, PS_LEFT,  3'd5, 4'd2};  // hit box edge
        vecs[7]  = '{10'd229, 10'd110, PS_LEFT,  3'd1, 4'd3};  // just outside hit box
        vecs[8]  = '{10'd238, 10'd110, PS_EMPTY, 3'd2, 4'd3};  // strike box edge
        vecs[9]  = '{10'd237, 10'd110, PS_EMPTY, 3'd1, 4'd3};  // just outside strike box
        vecs[10] = '{10'd250, 10'd98,  PS_BACK,  3'd5, 4'd2};
        vecs[11] = '{10'd262, 10'd122, PS_EMPTY, 3'd2, 4'd3};  // diagonal corner
        vecs[12] = '{10'd250, 10'd100, PS_FRONT, 3'd2, 4'd3};

        rst      = 1'b0;
        enable   = 1'b1;
        respawn  = 1'b0;
        gameover = 1'b0;
        set_player(10'd150, 10'd110, PS_EMPTY);
        #12;
        check("reset_state", enemy_state, 0);
        check("reset_h", enemy_h, 250);
        check("reset_v", enemy_v, 110);
        check("reset_hp", hp, 3);
        check("reset_att", is_attacked, 0);
        check("reset_def", defeated, 0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_hold", enemy_state, 0);

        for (int i = 0; i < 13; i++) begin
            set_player(vecs[i].ph, vecs[i].pv, vecs[i].ps);
            do_respawn();
            tick();
            check($sformatf("vec%0d_state", i), enemy_state, vecs[i].exp_state);
            check($sformatf("vec%0d_hp", i), hp, vecs[i].exp_hp);
        end

        // Full chase / windup / strike / cooldown cycle.
        set_player(10'd150, 10'd110, PS_EMPTY);
        do_respawn();
        wait_state(3'd2, "chase_to_windup", n);
        check("chase_cycles", n, 353);
        check("chase_h", enemy_h, 162);
        check("chase_v", enemy_v, 110);
        wait_state(3'd3, "windup_to_strike", n);
        check("windup_cycles", n, 30);
        check("strike_pulse", is_attacked, 1);
        tick();
        check("cooldown_state", enemy_state, 4);
        check("cooldown_att", is_attacked, 0);
        wait_state(3'd1, "cooldown_to_chase", n);
        check("cooldown_cycles", n, 60);

        // Asynchronous reset in the middle of a chase.
        #2 rst = 1'b0;
        #1;
        check("async_state", enemy_state, 0);
        check("async_h", enemy_h, 250);
        check("async_v", enemy_v, 110);
        check("async_hp", hp, 3);
        check("async_att", is_attacked, 0);
        rst = 1'b1;
        tick();

        // Player leaves reach during windup: strike is empty.
        do_respawn();
        wait_state(3'd2, "chase_to_windup2", n);
        player_h = 10'd100;
        wait_state(3'd3, "windup_to_strike2", n);
        check("miss_windup_cycles", n, 30);
        check("miss_pulse", is_attacked, 0);
        check("miss_h_static", enemy_h, 162);

        // Player hit on the cycle that would launch the strike.
        set_player(10'd150, 10'd110, PS_EMPTY);
        do_respawn();
        wait_state(3'd2, "chase_to_windup3", n);
        repeat (29) tick();
        check("late_windup", enemy_state, 2);
        player_state = PS_LEFT;
        tick();
        check("preempt_state", enemy_state, 5);
        check("preempt_att", is_attacked, 0);
        check("preempt_hp", hp, 2);
        player_state = PS_EMPTY;

        // Gameover freezes the enemy and blocks respawn.
        gameover = 1'b1;
        tick();
        check("go_state", enemy_state, 0);
        check("go_h", enemy_h, 162);
        check("go_hp", hp, 2);
        do_respawn();
        check("go_respawn_blocked", enemy_state, 0);
        check("go_respawn_hp", hp, 2);
        repeat (5) tick();
        check("go_no_pulse", is_attacked, 0);
        gameover = 1'b0;
        tick();
        check("go_release_idle", enemy_state, 0);

        // Stage disable.
        do_respawn();
        check("en_chase", enemy_state, 1);
        enable = 1'b0;
        tick();
        check("dis_idle", enemy_state, 0);
        do_respawn();
        check("dis_respawn_blocked", enemy_state, 0);
        enable = 1'b1;

        // Invulnerability window and death after three hits.
        set_player(10'd240, 10'd110, PS_LEFT);
        do_respawn();
        tick();
        check("hit1_state", enemy_state, 5);
        check("hit1_hp", hp, 2);
        repeat (99) tick();
        check("hurt_hold_state", enemy_state, 5);
        check("hurt_hold_hp", hp, 2);
        tick();
        check("hurt_exit", enemy_state, 1);
        check("hurt_exit_hp", hp, 2);
        tick();
        check("hit2_hp", hp, 1);
        check("hit2_state", enemy_state, 5);
        repeat (100) tick();
        check("hit2_exit", enemy_state, 1);
        tick();
        check("dead_state", enemy_state, 6);
        check("dead_hp", hp, 0);
        check("dead_flag", defeated, 1);
        player_h = 10'd150;
        repeat (20) tick();
        check("dead_hold", enemy_state, 6);
        check("dead_h_static", enemy_h, 250);
        player_state = PS_EMPTY;
        do_respawn();
        check("revive_state", enemy_state, 1);
        check("revive_hp", hp, 3);
        check("revive_flag", defeated, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
